// File: rtl/mic1_ifu_if.sv
// MIC-1 instruction fetch unit bundle.
// Datapath-side consume/redirect plus byte-wide memory port.
interface mic1_ifu_if;
    logic        pc_load;
    logic [31:0] pc_in;
    logic        consume1;
    logic        consume2;
    logic        mem_ren;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [7:0]  mbr;
    logic [15:0] mbr2;
    logic        mbr_valid;
    logic        mbr2_valid;

    modport master (
        input  pc_load, pc_in, consume1, consume2, mem_rdata,
        output mem_ren, mem_addr, mbr, mbr2, mbr_valid, mbr2_valid
    );

    modport slave (
        output pc_load, pc_in, consume1, consume2, mem_rdata,
        input  mem_ren, mem_addr, mbr, mbr2, mbr_valid, mbr2_valid
    );
endinterface

// File: rtl/mic1_ifu.sv
// MIC-1 instruction fetch unit: byte prefetch queue
// feeding MBR / MBR2 with one read in flight at a time.
module mic1_ifu #(
    parameter int          QDEPTH   = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic       clk,
    input  logic       rst,
    mic1_ifu_if.master bus
);
    localparam int          AW    = $clog2(QDEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(QDEPTH);

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_t;

    logic [7:0]    q [QDEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr1;
    logic [AW:0]   count;
    logic [AW:0]   cnt_nxt;
    logic          inflight;
    logic [31:0]   addr_q;
    logic [31:0]   fetch_addr;
    logic [1:0]    ncons;
    logic          issue;
    logic          mbr_v;
    logic          mbr2_v;
    occ_t          occ;

    // Occupancy decode of the byte queue
    always_comb begin
        occ = PARTIAL;
        if (count == '0)
            occ = EMPTY;
        else if (count == DEPTH)
            occ = FULL;
    end

    assign mbr_v   = (occ != EMPTY);
    assign mbr2_v  = (count >= (AW+1)'(2));
    assign rd_ptr1 = rd_ptr + AW'(1);

    assign bus.mbr_valid  = mbr_v;
    assign bus.mbr2_valid = mbr2_v;
    assign bus.mbr        = mbr_v ? q[rd_ptr] : 8'h00;
    assign bus.mbr2       = mbr2_v ? {q[rd_ptr], q[rd_ptr1]}
                                   : 16'h0000;
    assign bus.mem_ren    = inflight;
    assign bus.mem_addr   = addr_q;

    // Accept consumes only when enough bytes exist; consume2 wins
    always_comb begin
        ncons = 2'd0;
        if (bus.consume2 && mbr2_v)
            ncons = 2'd2;
        else if (bus.consume1 && mbr_v)
            ncons = 2'd1;
    end

    // Occupancy after this edge; refill whenever a slot remains
    assign cnt_nxt = count + (AW+1)'(inflight) - (AW+1)'(ncons);
    assign issue   = (cnt_nxt < DEPTH);

    // Write the returning byte at the tail (no bypass to mbr)
    always_ff @(posedge clk) begin
        if (!rst && !bus.pc_load && inflight)
            q[wr_ptr] <= bus.mem_rdata;
    end

    // Queue pointers, occupancy and fetch address sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            inflight   <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_addr <= RESET_PC;
        end else if (bus.pc_load) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            inflight   <= 1'b1;
            addr_q     <= bus.pc_in;
            fetch_addr <= bus.pc_in + 32'd1;
        end else begin
            count    <= cnt_nxt;
            rd_ptr   <= rd_ptr + AW'(ncons);
            wr_ptr   <= wr_ptr + AW'(inflight);
            inflight <= issue;
            if (issue) begin
                addr_q     <= fetch_addr;
                fetch_addr <= fetch_addr + 32'd1;
            end
        end
    end
endmodule

// File: doc/mic1_ifu.md
MIC1_IFU -- requirements
Module: mic1_ifu

Interface
REQ-001 The module SHALL have parameter QDEPTH, default 8, byte-queue depth (power of two, at least 4).
REQ-002 The module SHALL have parameter RESET_PC, default 32'h0, first byte address fetched after reset.
REQ-003 The design SHALL use one clock and a synchronous, active-high reset: clk in 1, all state updates on posedge clk; rst in 1.
REQ-004 The module SHALL have port pc_load, input, 1 bit: redirect fetch stream to pc_in.
REQ-005 The module SHALL have port pc_in, input, 32 bits: new byte address for pc_load.
REQ-006 The module SHALL have port consume1, input, 1 bit: datapath takes 1 byte (opcode or 8-bit operand).
REQ-007 The module SHALL have port consume2, input, 1 bit: datapath takes 2 bytes (16-bit operand).
REQ-008 The module SHALL have port mem_ren, output, 1 bit: byte-port read enable to main memory.
REQ-009 The module SHALL have port mem_addr, output, 32 bits: byte-port byte address to main memory.
REQ-010 The module SHALL have port mem_rdata, input, 8 bits: byte returned by main memory.
REQ-011 The module SHALL have port mbr, output, 8 bits: queue head byte.
REQ-012 The module SHALL have port mbr2, output, 16 bits: {head, head+1}, big-endian operand.
REQ-013 The module SHALL have port mbr_valid, output, 1 bit: at least 1 byte queued.
REQ-014 The module SHALL have port mbr2_valid, output, 1 bit: at least 2 bytes queued.

Function
REQ-015 mem_ren and mem_addr SHALL be registered, and the block SHALL allow at most 1 read in flight (inflight flag).
REQ-016 Memory latency SHALL be 1 cycle: a read driven after posedge N is captured from mem_rdata at posedge N+1, while mem_addr still holds the issued address.
REQ-017 mem_addr SHALL change only at a posedge that issues a new read or applies pc_load, and SHALL stay stable while the read is in flight.
REQ-018 Let ncons = 2 if consume2 is accepted, 1 if consume1 is accepted, else 0; at each posedge without rst or pc_load, count SHALL become count + inflight - ncons.
REQ-019 At each posedge without rst or pc_load, a new read SHALL be issued (mem_ren=1, mem_addr=fetch_addr, fetch_addr+1) iff count + inflight - ncons < QDEPTH; otherwise mem_ren=0.
REQ-020 Steady-state throughput SHALL be 1 byte per cycle.
REQ-021 consume2 SHALL be accepted only when mbr2_valid, and consume1 only when mbr_valid; a consume without the matching valid SHALL be ignored, with no state change.
REQ-022 When consume1 and consume2 are both high, consume2 SHALL take priority.
REQ-023 A captured byte SHALL NOT be visible on mbr in the same cycle it is captured: no bypass, visible on mbr from the next cycle.
REQ-024 mbr SHALL be 8'h00 when !mbr_valid, and mbr2 SHALL be 16'h0000 when !mbr2_valid.
REQ-025 On pc_load at a posedge: queue flushed (count=0), in-flight byte discarded, mem_addr=pc_in, mem_ren=1, fetch_addr=pc_in+1, inflight=1.
REQ-026 pc_load SHALL override any consume in the same cycle.
REQ-027 fetch_addr SHALL increment modulo 2^32, so 32'hFFFFFFFF is followed by 32'h0.
REQ-028 Queue pointers SHALL wrap modulo QDEPTH, and count SHALL never exceed QDEPTH or go below 0.
REQ-029 Occupancy states SHALL be decoded as: EMPTY (count=0), PARTIAL (0<count<QDEPTH), FULL (count=QDEPTH).
REQ-030 In FULL with no consume, mem_ren SHALL be 0.
REQ-031 A consume in FULL SHALL allow a read to be issued at the same edge.

Reset
REQ-032 While rst is high at a posedge: count=0, inflight=0, mem_ren=0, mem_addr=RESET_PC, fetch_addr=RESET_PC, mbr_valid=0, mbr2_valid=0.
REQ-033 rst SHALL have priority over pc_load and the consumes, and SHALL discard any in-flight byte.
REQ-034 At the first posedge after rst falls, the block SHALL issue a read of RESET_PC.

Verification
REQ-035 Cold fill: memory word0=32'h44332211, word1=32'h88776655; release reset, no consumes -> mem_addr 0,1,2..., mbr_valid 2 cycles after first read, mbr=8'h11, mbr2=16'h1122, count reaches 8, mem_ren=0 thereafter.
REQ-036 Stream: consume1 every cycle from first mbr_valid -> mbr sequence 11,22,33,44,55,66,77,88 on consecutive cycles, no bubbles.
REQ-037 Operand: with queue holding 11,22,33, assert consume2 -> next cycle mbr=8'h33; consume2 with count=1 -> ignored, count unchanged.
REQ-038 Redirect: in PARTIAL with read in flight, pc_load with pc_in=32'h5 -> mbr_valid=0 next cycle, mem_addr=5, then mbr=8'h66 after 2 cycles, stale byte never appears.
REQ-039 Full boundary: FULL, consume1 -> same edge mem_ren=1, count stays 8 after refill, no overflow.
REQ-040 Reset mid-operation: assert rst while FULL with read in flight -> next cycle mbr_valid=0, mem_ren=0, mem_addr=RESET_PC; fetch resumes from RESET_PC.
